// File: rtl/axi_trk_pkg.sv
// Shared types and defaults for the AXI burst beat tracker.
package axi_trk_pkg;

    localparam int unsigned LEN_WIDTH  = 8;
    localparam int unsigned BEAT_WIDTH = 32;

    typedef enum logic {
        TRK_IDLE,
        TRK_BURST
    } trk_state_e;

    typedef logic [BEAT_WIDTH-1:0] beat_num_t;

endpackage

// File: rtl/axi_beat_tracker_if.sv
// Snooped AXI address/data handshake signals observed by the beat tracker.
interface axi_beat_tracker_if
    import axi_trk_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = axi_trk_pkg::LEN_WIDTH
);
    logic                 axi_AWVALID;
    logic                 axi_AWREADY;
    logic [LEN_WIDTH-1:0] axi_AWLEN;
    logic                 axi_WVALID;
    logic                 axi_WREADY;
    logic                 axi_WLAST;
    logic                 axi_ARVALID;
    logic                 axi_ARREADY;
    logic [LEN_WIDTH-1:0] axi_ARLEN;
    logic                 axi_RVALID;
    logic                 axi_RREADY;
    logic                 axi_RLAST;

    modport master (
        output axi_AWVALID, axi_AWREADY, axi_AWLEN, axi_WVALID, axi_WREADY, axi_WLAST,
        output axi_ARVALID, axi_ARREADY, axi_ARLEN, axi_RVALID, axi_RREADY, axi_RLAST
    );

    modport slave (
        input axi_AWVALID, axi_AWREADY, axi_AWLEN, axi_WVALID, axi_WREADY, axi_WLAST,
        input axi_ARVALID, axi_ARREADY, axi_ARLEN, axi_RVALID, axi_RREADY, axi_RLAST
    );
endinterface

// File: rtl/axi_len_fifo.sv
// Burst-length queue; a push while full is dropped unless a pop frees a slot that cycle.
module axi_len_fifo
    import axi_trk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = LEN_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/axi_beat_tracker.sv
// Passive AXI write/read burst beat tracker feeding the protocol assertion checker.
// Define AXI_BEAT_TRACKER_CHK_EN to build the sticky WLAST/RLAST/queue-overflow checks.
module axi_beat_tracker
    import axi_trk_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = axi_trk_pkg::LEN_WIDTH,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 axi_ACLK,
    input  logic                 axi_ARESET,
    axi_beat_tracker_if.slave    axi,
    output beat_num_t            wr_beat_num,
    output beat_num_t            next_rd_beat_num,
    output logic [LEN_WIDTH-1:0] latched_awlen,
    output logic [LEN_WIDTH-1:0] latched_arlen,
    output logic                 wr_active,
    output logic                 rd_active,
    output logic                 aw_full,
    output logic                 ar_full,
    output logic                 wlast_err,
    output logic                 rlast_err,
    output logic                 q_ovf_err
);
    // Index 0 is the write direction, index 1 the read direction.
    logic [1:0]                addr_hs;
    logic [1:0]                data_hs;
    logic [1:0]                data_last;
    logic [1:0][LEN_WIDTH-1:0] addr_len;
    logic [1:0][LEN_WIDTH-1:0] cnt_q;
    logic [1:0][LEN_WIDTH-1:0] len_out;
    logic [1:0]                active_q;
    logic [1:0]                full_q;
    logic [1:0]                last_err_q;
    logic [1:0]                ovf_err_q;

    assign addr_hs[0]   = axi.axi_AWVALID && axi.axi_AWREADY;
    assign addr_hs[1]   = axi.axi_ARVALID && axi.axi_ARREADY;
    assign data_hs[0]   = axi.axi_WVALID && axi.axi_WREADY;
    assign data_hs[1]   = axi.axi_RVALID && axi.axi_RREADY;
    assign data_last[0] = axi.axi_WLAST;
    assign data_last[1] = axi.axi_RLAST;
    assign addr_len[0]  = axi.axi_AWLEN;
    assign addr_len[1]  = axi.axi_ARLEN;

    for (genvar d = 0; d < 2; d++) begin : g_dir
        trk_state_e           state;
        logic [LEN_WIDTH-1:0] head;
        logic [LEN_WIDTH-1:0] cur_len;
        logic [LEN_WIDTH-1:0] len_hold;
        logic [LEN_WIDTH-1:0] cnt;
        logic                 full;
        logic                 empty;
        logic                 avail;
        logic                 beat;
        logic                 last;
        logic                 push;
        logic                 pop;

        axi_len_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (LEN_WIDTH)
        ) u_fifo (
            .clk   (axi_ACLK),
            .rst   (axi_ARESET),
            .push  (push),
            .pop   (pop),
            .din   (addr_len[d]),
            .head  (head),
            .full  (full),
            .empty (empty)
        );

        // An empty queue with a same-cycle address handshake forwards the new length.
        assign avail   = !empty || addr_hs[d];
        assign cur_len = empty ? addr_len[d] : head;
        assign beat    = data_hs[d] && avail;
        assign last    = beat && (cnt == cur_len);
        assign pop     = last && !empty;
        assign push    = addr_hs[d] && !(empty && last);

        always_ff @(posedge axi_ACLK or posedge axi_ARESET) begin
            if (axi_ARESET) begin
                state    <= TRK_IDLE;
                cnt      <= '0;
                len_hold <= '0;
            end else begin
                if (avail) len_hold <= cur_len;
                if (last) begin
                    cnt   <= '0;
                    state <= TRK_IDLE;
                end else if (beat) begin
                    if (cnt != '1) cnt <= cnt + LEN_WIDTH'(1);
                    state <= TRK_BURST;
                end
            end
        end

        assign cnt_q[d]    = cnt;
        assign len_out[d]  = avail ? cur_len : len_hold;
        assign active_q[d] = (state == TRK_BURST);
        assign full_q[d]   = full;

`ifdef AXI_BEAT_TRACKER_CHK_EN
        logic last_err;
        logic ovf_err;

        always_ff @(posedge axi_ACLK or posedge axi_ARESET) begin
            if (axi_ARESET) begin
                last_err <= 1'b0;
                ovf_err  <= 1'b0;
            end else begin
                if (beat && (data_last[d] != (cnt == cur_len))) last_err <= 1'b1;
                if (push && full && !pop) ovf_err <= 1'b1;
            end
        end

        assign last_err_q[d] = last_err;
        assign ovf_err_q[d]  = ovf_err;
`else
        assign last_err_q[d] = 1'b0;
        assign ovf_err_q[d]  = 1'b0;
`endif
    end

`ifndef AXI_BEAT_TRACKER_CHK_EN
    logic unused_last;
    assign unused_last = ^data_last;
`endif

    assign wr_beat_num      = beat_num_t'(cnt_q[0]);
    assign next_rd_beat_num = beat_num_t'(cnt_q[1]);
    assign latched_awlen    = len_out[0];
    assign latched_arlen    = len_out[1];
    assign wr_active        = active_q[0];
    assign rd_active        = active_q[1];
    assign aw_full          = full_q[0];
    assign ar_full          = full_q[1];
    assign wlast_err        = last_err_q[0];
    assign rlast_err        = last_err_q[1];
    assign q_ovf_err        = |ovf_err_q;

endmodule

// File: tb/tb_axi_beat_tracker.sv
// Randomized and directed bench for axi_beat_tracker against a queue-based burst model.
module tb_axi_beat_tracker;
    import axi_trk_pkg::*;

    localparam int unsigned LW    = 8;
    localparam int unsigned DEPTH = 4;
`ifdef AXI_BEAT_TRACKER_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_v[2], a_r[2], d_v[2], d_r[2], d_last[2];
    logic [LW-1:0] a_len[2];

    beat_num_t     wr_beat_num, next_rd_beat_num;
    logic [LW-1:0] latched_awlen, latched_arlen;
    logic          wr_active, rd_active, aw_full, ar_full;
    logic          wlast_err, rlast_err, q_ovf_err;

    axi_beat_tracker_if #(.LEN_WIDTH(LW)) bus ();

    assign bus.axi_AWVALID = a_v[0];
    assign bus.axi_AWREADY = a_r[0];
    assign bus.axi_AWLEN   = a_len[0];
    assign bus.axi_WVALID  = d_v[0];
    assign bus.axi_WREADY  = d_r[0];
    assign bus.axi_WLAST   = d_last[0];
    assign bus.axi_ARVALID = a_v[1];
    assign bus.axi_ARREADY = a_r[1];
    assign bus.axi_ARLEN   = a_len[1];
    assign bus.axi_RVALID  = d_v[1];
    assign bus.axi_RREADY  = d_r[1];
    assign bus.axi_RLAST   = d_last[1];

    axi_beat_tracker #(.LEN_WIDTH(LW), .DEPTH(DEPTH)) dut (
        .axi_ACLK         (clk),
        .axi_ARESET       (rst),
        .axi              (bus),
        .wr_beat_num      (wr_beat_num),
        .next_rd_beat_num (next_rd_beat_num),
        .latched_awlen    (latched_awlen),
        .latched_arlen    (latched_arlen),
        .wr_active        (wr_active),
        .rd_active        (rd_active),
        .aw_full          (aw_full),
        .ar_full          (ar_full),
        .wlast_err        (wlast_err),
        .rlast_err        (rlast_err),
        .q_ovf_err        (q_ovf_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending lengths per direction, current beat index, sticky flags.
    int qm[2][DEPTH];
    int qn[2];
    int idx[2];
    int hold[2];
    bit act[2];
    bit lerr[2];
    bit ovf;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            qn[d] = 0; idx[d] = 0; hold[d] = 0; act[d] = 0; lerr[d] = 0;
        end
        ovf = 0;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            a_v[d] = 0; a_r[d] = 0; a_len[d] = '0; d_v[d] = 0; d_r[d] = 0; d_last[d] = 0;
        end
    endtask

    function automatic bool_len_known(input int d);
        return (qn[d] > 0) || (a_v[d] && a_r[d]);
    endfunction

    function automatic int cur_len(input int d);
        return (qn[d] > 0) ? qm[d][0] : int'(a_len[d]);
    endfunction

    // True when the beat presented this cycle should carry xLAST.
    function automatic bit exp_last(input int d);
        return bool_len_known(d) && (idx[d] == cur_len(d));
    endfunction

    task automatic check_cycle();
        for (int d = 0; d < 2; d++) begin
            string p = (d == 0) ? "wr" : "rd";
            int exp_len = bool_len_known(d) ? cur_len(d) : hold[d];
            chk({p, "_beat"},   (d == 0) ? int'(wr_beat_num)   : int'(next_rd_beat_num), idx[d]);
            chk({p, "_len"},    (d == 0) ? int'(latched_awlen) : int'(latched_arlen),    exp_len);
            chk({p, "_active"}, (d == 0) ? int'(wr_active)     : int'(rd_active),        int'(act[d]));
            chk({p, "_full"},   (d == 0) ? int'(aw_full)       : int'(ar_full),          int'(qn[d] == DEPTH));
            chk({p, "_lasterr"},(d == 0) ? int'(wlast_err)     : int'(rlast_err),        int'(CHK && lerr[d]));
        end
        chk("q_ovf_err", int'(q_ovf_err), int'(CHK && ovf));
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit ahs      = a_v[d] && a_r[d];
            bit dhs      = d_v[d] && d_r[d];
            bit have     = bool_len_known(d);
            int len      = cur_len(d);
            bit consumed = 0;
            if (have) hold[d] = len;
            if (dhs && have) begin
                if (d_last[d] != (idx[d] == len)) lerr[d] = 1;
                if (idx[d] == len) begin
                    if (qn[d] > 0) begin
                        for (int k = 0; k < DEPTH - 1; k++) qm[d][k] = qm[d][k+1];
                        qn[d]--;
                    end else begin
                        consumed = 1;
                    end
                    idx[d] = 0;
                    act[d] = 0;
                end else begin
                    if (idx[d] < (1 << LW) - 1) idx[d]++;
                    act[d] = 1;
                end
            end
            if (ahs && !consumed) begin
                if (qn[d] < DEPTH) begin
                    qm[d][qn[d]] = int'(a_len[d]);
                    qn[d]++;
                end else begin
                    ovf = 1;
                end
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs are checked 1 time unit later.
    task automatic cycle();
        #1;
        check_cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        #1;
        model_reset();
        check_cycle();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        do_reset();

        // AWLEN=3 then four back-to-back W beats.
        a_v[0] = 1; a_r[0] = 1; a_len[0] = LW'(3);
        cycle();
        a_v[0] = 0;
        for (int i = 0; i < 4; i++) begin
            d_v[0] = 1; d_r[0] = 1; d_last[0] = (i == 3);
            cycle();
        end
        clear_inputs();
        cycle();

        // AWLEN=0 with the single W beat in the same cycle.
        a_v[0] = 1; a_r[0] = 1; a_len[0] = '0;
        d_v[0] = 1; d_r[0] = 1; d_last[0] = 1;
        cycle();
        clear_inputs();
        cycle();

        // Five ARs with no R traffic: queue fills and the fifth overflows.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            a_v[1] = 1; a_r[1] = 1; a_len[1] = LW'(1);
            cycle();
        end
        clear_inputs();
        cycle();

        // ARLEN=2 with RLAST wrongly on beat 1.
        do_reset();
        a_v[1] = 1; a_r[1] = 1; a_len[1] = LW'(2);
        cycle();
        a_v[1] = 0;
        for (int i = 0; i < 3; i++) begin
            d_v[1] = 1; d_r[1] = 1; d_last[1] = (i == 1);
            cycle();
        end
        clear_inputs();
        cycle();

        // Reset during beat 2 of an AWLEN=7 burst, then a fresh AWLEN=1 burst.
        do_reset();
        a_v[0] = 1; a_r[0] = 1; a_len[0] = LW'(7);
        cycle();
        a_v[0] = 0;
        for (int i = 0; i < 2; i++) begin
            d_v[0] = 1; d_r[0] = 1; d_last[0] = 0;
            cycle();
        end
        #1;
        check_cycle();
        rst = 1;
        #1;
        model_reset();
        check_cycle();
        clear_inputs();
        @(negedge clk);
        rst = 0;
        a_v[0] = 1; a_r[0] = 1; a_len[0] = LW'(1);
        cycle();
        a_v[0] = 0;
        for (int i = 0; i < 2; i++) begin
            d_v[0] = 1; d_r[0] = 1; d_last[0] = (i == 1);
            cycle();
        end
        clear_inputs();
        cycle();

        // Random traffic with correct xLAST, independent per direction.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            for (int d = 0; d < 2; d++) begin
                a_v[d]   = ($urandom_range(0, 3) == 0);
                a_r[d]   = $urandom_range(0, 1) != 0;
                a_len[d] = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(4, 6))
                                                       : LW'($urandom_range(0, 3));
                d_v[d]   = $urandom_range(0, 1) != 0;
                d_r[d]   = $urandom_range(0, 2) != 0;
                d_last[d] = exp_last(d);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_beat_tracker.md
# axi_beat_tracker

Passive AXI burst-tracking stage that snoops the AW/W and AR/R channels and produces the per-burst bookkeeping consumed by the AXI protocol assertion checker: current write beat index, current read beat index, and the burst length latched for the burst in progress. Sits in the testbench/monitor layer beside the AXI interface, directly upstream of the assertion module. Queues up to DEPTH outstanding address requests per direction, so back-to-back bursts track correctly.

## Interface
- LEN_WIDTH, 8, width of AxLEN and of the latched length outputs
- DEPTH, 4, outstanding address entries queued per direction (power of two, ≥2)
- axi_ACLK  in  1  clock; all state updates on rising edge
- axi_ARESET  in  1  reset; asynchronous and active-high
- axi_AWVALID, axi_AWREADY  in  1 each  write address handshake
- axi_AWLEN  in  LEN_WIDTH  write burst length (beats−1)
- axi_WVALID, axi_WREADY, axi_WLAST  in  1 each  write data handshake and last flag
- axi_ARVALID, axi_ARREADY  in  1 each  read address handshake
- axi_ARLEN  in  LEN_WIDTH  read burst length (beats−1)
- axi_RVALID, axi_RREADY, axi_RLAST  in  1 each  read data handshake and last flag
- wr_beat_num  out  32 (integer)  0-based index of the W beat currently presented
- next_rd_beat_num  out  32 (integer)  0-based index of the R beat currently presented
- latched_awlen  out  LEN_WIDTH  AWLEN of the write burst in progress
- latched_arlen  out  LEN_WIDTH  ARLEN of the read burst in progress
- wr_active, rd_active  out  1 each  burst in progress (state BURST)
- aw_full, ar_full  out  1 each  length queue holds DEPTH entries
- wlast_err, rlast_err, q_ovf_err  out  1 each  sticky protocol flags (see Configuration)

## Operation
- Per direction: length FIFO (DEPTH×LEN_WIDTH), beat counter, two-state FSM IDLE/BURST. Write and read paths are identical and independent; write described.
- AW handshake (AWVALID&&AWREADY) pushes AWLEN. Push when full: entry dropped, q_ovf_err set.
- latched_awlen = FIFO head; when FIFO empty and AW handshake in same cycle, bypass: latched_awlen = axi_AWLEN combinationally. Empty and no handshake: holds last value.
- IDLE→BURST on W handshake with a length available (head or bypass) and beat not last. A W handshake whose index equals the length (incl. AWLEN=0) completes the burst: pop FIFO, counter←0, FSM→IDLE (or stays BURST if next head already valid, on next beat).
- Within burst each W handshake increments wr_beat_num; counter saturates at 2^LEN_WIDTH−1.
- Simultaneous push and pop: both occur, count unchanged. Push to empty with same-cycle single-beat completion: net FIFO empty.
- W handshake with no length available (FIFO empty, no bypass): beat ignored, counter unchanged.
- Read path: same with AR/R/RLAST; output named next_rd_beat_num.

## Timing
- Reset values: wr_beat_num=0, next_rd_beat_num=0, latched_awlen=0, latched_arlen=0, wr_active=0, rd_active=0, aw_full=0, ar_full=0, all err flags=0; FIFOs empty, FSMs IDLE.
- Counters, FIFOs, flags registered: update one cycle after the handshake edge. Beat index output valid in the same cycle as the beat it names.
- latched_axlen: zero latency via bypass, otherwise registered head.
- Reset asserted mid-burst: all state cleared asynchronously; partial burst discarded, no error raised.

## Configuration
- AXI_BEAT_TRACKER_CHK_EN defined: wlast_err set when WLAST disagrees with (wr_beat_num == latched_awlen) on a W handshake; rlast_err likewise for R; q_ovf_err on queue overflow. Flags sticky until reset.
- Undefined: checking logic not compiled; wlast_err, rlast_err, q_ovf_err tied 0; tracking unchanged.

## Structure
- Shared package axi_trk_pkg: state enum (TRK_IDLE, TRK_BURST), LEN_WIDTH default, beat-count typedef.
- One sub-module axi_len_fifo (param depth/width, push/pop/full/empty/head, async active-high reset), instantiated once per direction.

## Test plan
- Reset then AW AWLEN=3, W beats on 4 consecutive cycles -> wr_beat_num 0,1,2,3; latched_awlen=3; WLAST on beat 3 leaves wlast_err=0; FIFO empty, wr_active=0 after.
- AW AWLEN=0 with WVALID same cycle -> bypass latched_awlen=0, wr_beat_num=0, burst completes immediately, FIFO stays empty.
- Five ARs (ARLEN=1) with RREADY held low -> ar_full=1 after 4, 5th dropped, q_ovf_err=1 (CHK_EN); undefined build -> q_ovf_err=0.
- AR ARLEN=2, RLAST on beat 1 -> rlast_err=1, next_rd_beat_num continues to 2.
- Reset asserted during beat 2 of AWLEN=7 burst -> all outputs 0 same cycle; new AWLEN=1 burst afterward tracks from beat 0.
